// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: byte-stream loader handshake into the run controller
// Signals:
//   valid  loader byte valid (master -> slave)
//   ready  controller accepts the byte this cycle (slave -> master)
//   addr   byte address in instruction memory
//   data   loader byte
//   last   final byte of the program
interface core_run_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              last;
    modport master (output valid, addr, data, last, input ready);
    modport slave  (input valid, addr, data, last, output ready);
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: loads a program into imem, then runs/halts the RV32I core
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   ld                loader stream (slave side of core_run_ctrl_if)
//   start, clear      run request (level); HALT -> IDLE return
//   instruction       instruction currently fetched by the core
//   imem_we/waddr/wdata  registered instruction-memory byte write port
//   core_rst, core_en core reset (active high) and clock enable
//   loaded, halted, timeout  status flags
//   cycle_count       RUN cycles in the current or last run
module core_run_ctrl #(
    parameter int          ADDR_W      = 12,
    parameter int          MAX_CYCLES  = 100,
    parameter logic [31:0] EBREAK_INSN = 32'h00100073
) (
    input  logic               clk,
    input  logic               rst,
    core_run_ctrl_if.slave     ld,
    input  logic               start,
    input  logic               clear,
    input  logic [31:0]        instruction,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_waddr,
    output logic [7:0]         imem_wdata,
    output logic               core_rst,
    output logic               core_en,
    output logic               loaded,
    output logic               halted,
    output logic               timeout,
    output logic [31:0]        cycle_count
);
    typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, HALT} state_t;
    state_t state;
    logic accept;
    logic is_ebreak;
    logic at_limit;
    assign ld.ready  = (state == IDLE) || (state == LOAD);
    assign accept    = ld.valid && ld.ready;
    assign is_ebreak = instruction == EBREAK_INSN;
    assign at_limit  = cycle_count == 32'(MAX_CYCLES - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            imem_we     <= 1'b0;
            imem_waddr  <= '0;
            imem_wdata  <= '0;
            core_rst    <= 1'b1;
            core_en     <= 1'b0;
            loaded      <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            imem_we <= accept;
            if (accept) begin
                imem_waddr <= ld.addr;
                imem_wdata <= ld.data;
            end
            case (state)
                IDLE: begin
                    // a load beat wins over start; a lone last-beat keeps us in IDLE
                    if (accept) begin
                        loaded <= ld.last;
                        if (!ld.last)
                            state <= LOAD;
                    end else if (start && loaded) begin
                        state <= RELEASE;
                    end
                end
                LOAD: begin
                    if (accept && ld.last) begin
                        state  <= IDLE;
                        loaded <= 1'b1;
                    end
                end
                RELEASE: begin
                    // the extra cycle lets the final imem write land before the first fetch
                    state       <= RUN;
                    cycle_count <= '0;
                    halted      <= 1'b0;
                    timeout     <= 1'b0;
                    core_rst    <= 1'b0;
                    core_en     <= 1'b1;
                end
                RUN: begin
                    if (is_ebreak) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        core_en <= 1'b0;
                    end else begin
                        cycle_count <= cycle_count + 32'd1;
                        if (at_limit) begin
                            state   <= HALT;
                            halted  <= 1'b1;
                            timeout <= 1'b1;
                            core_en <= 1'b0;
                        end
                    end
                end
                HALT: begin
                    if (clear) begin
                        state       <= IDLE;
                        halted      <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        core_rst    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: random loads and runs of core_run_ctrl against a program-level model
module tb_core_run_ctrl;
    localparam int          MAXC     = 100;
    localparam logic [31:0] EBREAK   = 32'h00100073;
    localparam logic [31:0] JAL_SELF = 32'h0000006f;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] instruction;
    logic        imem_we;
    logic [11:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic        core_rst, core_en, loaded, halted, timeout;
    logic [31:0] cycle_count;

    core_run_ctrl_if #(.ADDR_W(12)) ld ();

    core_run_ctrl #(.ADDR_W(12), .MAX_CYCLES(MAXC), .EBREAK_INSN(EBREAK)) dut (
        .clk(clk), .rst(rst), .ld(ld), .start(start), .clear(clear),
        .instruction(instruction), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .core_rst(core_rst), .core_en(core_en),
        .loaded(loaded), .halted(halted), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Tiny core: fetches from memory filled only through the DUT's write port,
    // executes addi and the jal-to-self loop.
    bit   [7:0]  mem [4096];
    logic [31:0] pc;
    logic [31:0] xr [32];
    logic [11:0] pa;
    assign pa = pc[11:0];
    assign instruction = {mem[pa + 12'd3], mem[pa + 12'd2], mem[pa + 12'd1], mem[pa]};

    always @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
        if (core_rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) xr[i] <= 32'd0;
        end else if (core_en) begin
            pc <= (instruction == JAL_SELF) ? pc : pc + 32'd4;
            if (instruction[6:0] == 7'h13 && instruction[11:7] != 5'd0)
                xr[instruction[11:7]] <= xr[instruction[19:15]] + {{20{instruction[31]}}, instruction[31:20]};
        end
    end

    // Every accepted beat must appear on the write port exactly one cycle later.
    logic        mon_acc;
    logic [11:0] mon_a;
    logic [7:0]  mon_d;
    always @(posedge clk) begin
        mon_acc = rst && ld.valid && ld.ready;
        mon_a   = ld.addr;
        mon_d   = ld.data;
        #1;
        check("imem_we", imem_we, mon_acc);
        if (mon_acc) begin
            check("imem_waddr", imem_waddr, mon_a);
            check("imem_wdata", imem_wdata, mon_d);
        end
    end

    // Reference: program image as the bench sent it, and run outcome from it.
    bit [7:0] ref_mem [4096];

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[12'(a + 3)], ref_mem[12'(a + 2)], ref_mem[12'(a + 1)], ref_mem[12'(a)]};
    endfunction

    function automatic void ref_run(output int cnt, output bit to);
        int a = 0;
        cnt = MAXC;
        to  = 1'b1;
        for (int s = 0; s < MAXC; s++) begin
            logic [31:0] w = ref_word(a);
            if (w == EBREAK) begin
                cnt = s;
                to  = 1'b0;
                return;
            end
            if (w != JAL_SELF) a = (a + 4) % 4096;
        end
    endfunction

    function automatic logic [31:0] rand_addi();
        return {12'($urandom), 5'($urandom_range(0, 7)), 3'b000, 5'($urandom_range(1, 7)), 7'h13};
    endfunction

    task automatic load_words(input logic [31:0] w [$]);
        int nb = w.size() * 4;
        for (int i = 0; i < nb; i++) begin
            if (i == 3 || $urandom_range(0, 3) == 0) begin
                ld.valid = 1'b0;
                @(negedge clk);
            end
            ld.valid = 1'b1;
            ld.addr  = 12'(i);
            ld.data  = w[i / 4][8 * (i % 4) +: 8];
            ld.last  = (i == nb - 1);
            ref_mem[i] = ld.data;
            check("load_ready", ld.ready, 1);
            @(negedge clk);
            if (i == 0 && nb > 1) check("loaded_clr", loaded, 0);
        end
        ld.valid = 1'b0;
        ld.last  = 1'b0;
        check("loaded_set", loaded, 1);
        check("load_idle_rst", core_rst, 1);
    endtask

    task automatic run_check(input string tag, input int x2_exp);
        int  ec;
        bit  et;
        int  n = 0;
        logic [31:0] cnt_hold;
        ref_run(ec, et);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_rel_rst"}, core_rst, 1);
        check({tag, "_rel_en"}, core_en, 0);
        check({tag, "_rel_rdy"}, ld.ready, 0);
        for (int i = 0; i < 400 && !halted; i++) begin
            @(negedge clk);
            check({tag, "_run_rdy"}, ld.ready, 0);
            if (core_en) begin
                n++;
                check({tag, "_run_cnt"}, cycle_count, n - 1);
            end
            if (!halted) begin
                ld.valid = 1'($urandom);
                ld.addr  = 12'($urandom);
                ld.data  = 8'($urandom);
                ld.last  = 1'($urandom);
                start    = 1'($urandom);
                clear    = 1'($urandom);
            end else begin
                ld.valid = 1'b0;
                ld.last  = 1'b0;
                clear    = 1'b0;
                start    = 1'b1;
            end
        end
        check({tag, "_halted"}, halted, 1);
        check({tag, "_en_cycles"}, n, et ? MAXC : ec + 1);
        check({tag, "_count"}, cycle_count, ec);
        check({tag, "_timeout"}, timeout, et);
        check({tag, "_halt_en"}, core_en, 0);
        check({tag, "_halt_rst"}, core_rst, 0);
        if (x2_exp >= 0) check({tag, "_x2"}, xr[2], x2_exp);
        cnt_hold = cycle_count;
        repeat (3) @(negedge clk);
        check({tag, "_hold_halted"}, halted, 1);
        check({tag, "_hold_count"}, cycle_count, cnt_hold);
        check({tag, "_hold_en"}, core_en, 0);
        if (x2_exp >= 0) check({tag, "_hold_x2"}, xr[2], x2_exp);
        start = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check({tag, "_clr_halted"}, halted, 0);
        check({tag, "_clr_timeout"}, timeout, 0);
        check({tag, "_clr_count"}, cycle_count, 0);
        check({tag, "_clr_loaded"}, loaded, 1);
        check({tag, "_clr_rst"}, core_rst, 1);
        check({tag, "_clr_rdy"}, ld.ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0] p [$];
        ld.valid = 1'b0;
        ld.addr  = '0;
        ld.data  = '0;
        ld.last  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_core_rst", core_rst, 1);
        check("rst_core_en", core_en, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_waddr", imem_waddr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_loaded", loaded, 0);
        check("rst_halted", halted, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", ld.ready, 1);
        check("idle_core_rst", core_rst, 1);

        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("nostart_ready", ld.ready, 1);
        check("nostart_rst", core_rst, 1);

        p = '{32'h00500093, 32'h00308113, EBREAK};
        load_words(p);
        run_check("ebreak", 8);
        run_check("rerun", 8);

        p = '{JAL_SELF};
        load_words(p);
        run_check("watchdog", -1);

        p = {};
        for (int i = 0; i < 99; i++) p.push_back(32'h00108093);
        p.push_back(EBREAK);
        load_words(p);
        run_check("ebreak_last", -1);

        @(negedge clk);
        ld.valid = 1'b1;
        ld.addr  = 12'd4000;
        ld.data  = 8'($urandom);
        ld.last  = 1'b1;
        start    = 1'b1;
        ref_mem[4000] = ld.data;
        @(negedge clk);
        ld.valid = 1'b0;
        ld.last  = 1'b0;
        start    = 1'b0;
        check("prio_rst", core_rst, 1);
        check("prio_ready", ld.ready, 1);
        check("prio_loaded", loaded, 1);

        for (int t = 0; t < 6; t++) begin
            int k = $urandom_range(0, 120);
            p = {};
            for (int i = 0; i < 100 && i <= k; i++)
                p.push_back(i == k ? EBREAK : ($urandom_range(0, 15) == 0 ? JAL_SELF : rand_addi()));
            load_words(p);
            run_check("rand", -1);
        end

        p = {};
        for (int i = 0; i < 100; i++) p.push_back(rand_addi());
        load_words(p);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        check("abort_pre_count", cycle_count, 19);
        #2 rst = 1'b0;
        #1;
        check("abort_core_rst", core_rst, 1);
        check("abort_core_en", core_en, 0);
        check("abort_count", cycle_count, 0);
        check("abort_loaded", loaded, 0);
        check("abort_halted", halted, 0);
        check("abort_imem_we", imem_we, 0);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        check("abort_nostart_ready", ld.ready, 1);
        check("abort_nostart_rst", core_rst, 1);
        check("abort_nostart_en", core_en, 0);

        p = '{32'h00500093, 32'h00308113, EBREAK};
        load_words(p);
        run_check("reload", 8);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
